// File: rtl/arbiter_rr_n_if.sv
// Request/grant bundle between N requesters and the round-robin arbiter.
// The requester side drives req; the arbiter side drives the registered grant outputs.
interface arbiter_rr_n_if #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
);
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_valid;

  modport master (output req, input gnt, input gnt_id, input gnt_valid);
  modport slave  (input req, output gnt, output gnt_id, output gnt_valid);
endinterface

// File: rtl/arbiter_rr_n.sv
// N-requester round-robin arbiter with grant hold and a hold-timeout that
// bounds how long one requester can keep the resource. All outputs registered.
module arbiter_rr_n #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDW      = $clog2(N)
) (
  input logic           clk,
  input logic           rst,
  arbiter_rr_n_if.slave bus
);

  localparam int HCW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_reg, state_next;
  logic [IDW-1:0] ptr_reg, ptr_next;
  logic [IDW-1:0] id_reg, id_next;
  logic [HCW-1:0] hcnt_reg, hcnt_next;
  logic [N-1:0]   gnt_reg, gnt_next;
  logic           valid_reg, valid_next;

  logic [IDW-1:0] ptr_after;
  logic [IDW-1:0] pick_base;
  logic [IDW-1:0] win;
  logic [N-1:0]   others;
  logic [N-1:0]   cand;
  logic [N-1:0]   win_onehot;
  logic           holder_req;
  logic           timed_out;
  logic           found;

  // Requests with the current holder removed (used when the holder times out),
  // and the one-hot form of the search winner.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_vec
      assign others[gi]     = bus.req[gi] & (id_reg != IDW'(gi));
      assign win_onehot[gi] = (win == IDW'(gi));
    end
  endgenerate

  assign holder_req = bus.req[id_reg];
  assign timed_out  = (MAX_HOLD != 0) && (hcnt_reg == HCW'(MAX_HOLD));
  // Pointer advance wraps explicitly so non-power-of-two N never reaches N.
  assign ptr_after  = (id_reg == IDW'(N - 1)) ? '0 : id_reg + IDW'(1);

  // Round-robin search: first set bit of cand starting at pick_base, wrapping at N.
  always_comb begin
    int idx;
    idx       = 0;
    pick_base = (state_reg == GRANT) ? ptr_after : ptr_reg;
    cand      = (state_reg == GRANT && holder_req) ? others : bus.req;
    found     = 1'b0;
    win       = '0;
    // Walk backwards so the lowest rotated position wins.
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(pick_base) + k;
      if (idx >= N) idx = idx - N;
      if (cand[idx[IDW-1:0]]) begin
        found = 1'b1;
        win   = idx[IDW-1:0];
      end
    end
  end

  // Next-state and next-output logic for the IDLE/GRANT machine.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    id_next    = id_reg;
    hcnt_next  = hcnt_reg;
    gnt_next   = gnt_reg;
    valid_next = valid_reg;
    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next = GRANT;
          id_next    = win;
          gnt_next   = win_onehot;
          valid_next = 1'b1;
          hcnt_next  = HCW'(1);
        end
      end
      GRANT: begin
        if (!holder_req) begin
          // Release: hand over with no bubble, or go idle if nobody is asking.
          ptr_next = ptr_after;
          if (found) begin
            id_next   = win;
            gnt_next  = win_onehot;
            hcnt_next = HCW'(1);
          end else begin
            state_next = IDLE;
            gnt_next   = '0;
            valid_next = 1'b0;
          end
        end else if (!timed_out) begin
          // Hold: counter only matters when a limit exists.
          if (MAX_HOLD != 0) hcnt_next = hcnt_reg + HCW'(1);
        end else begin
          // Timeout: pass to another requester if any, else re-grant the holder.
          ptr_next  = ptr_after;
          hcnt_next = HCW'(1);
          if (found) begin
            id_next  = win;
            gnt_next = win_onehot;
          end
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
        valid_next = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      id_reg    <= '0;
      hcnt_reg  <= '0;
      gnt_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      id_reg    <= id_next;
      hcnt_reg  <= hcnt_next;
      gnt_reg   <= gnt_next;
      valid_reg <= valid_next;
    end
  end

  assign bus.gnt       = gnt_reg;
  assign bus.gnt_id    = id_reg;
  assign bus.gnt_valid = valid_reg;

endmodule
